fnd_scan_controller: RTL and testbench
======================================

Name: fnd_scan_controller

Overview:
- Time-multiplexed scan controller for the common-anode 7-segment (FND) display.
- Sequences a 3-bit digit-select counter through DIGITS positions at a prescaled rate and drives one-hot active-low digit commons.
- Decodes the selected 4-bit digit to active-low segments, with inter-digit ghosting guard, leading-zero blanking and per-frame data snapshot.
- Sits between the clock/counter datapath (BCD digit values) and the board FND pins.

Parameters:
- CLK_DIV, 100000, clock cycles each digit is lit (SHOW dwell); legal range 2..2^20.
- DIGITS, 4, number of scanned digits; legal range 1..8 (3-bit select).
- BLANK_CYCLES, 16, clock cycles all commons are off between digits; 0 = no guard state.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_enable  in  1  1 = scanning; 0 = display dark, sequencer parked.
- i_digits  in  4*DIGITS  packed hex digits; [3:0] = digit 0 (rightmost).
- i_dp  in  DIGITS  decimal point per digit, 1 = lit.
- i_lz_blank  in  1  1 = blank leading zeros.
- o_com  out  DIGITS  digit commons, active-low, at most one bit low.
- o_seg  out  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}.
- o_digit_sel  out  3  index of the current/next digit.
- o_frame_start  out  1  one-cycle pulse when digit 0 SHOW begins.

Behaviour:
- Reset (async, i_reset_n=0):
  - state=IDLE, o_com all 1, o_seg=8'hFF, o_digit_sel=0, o_frame_start=0.
  - Prescaler and snapshot register cleared.
- All outputs are registered. Seg codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E. The DP lit clears bit 7.
- FSM states IDLE, SHOW, GUARD:
  - IDLE -> SHOW when i_enable=1.
    - On that transition: digit_sel=0, prescaler=0, snapshot<=i_digits/i_dp.
    - o_frame_start pulses on the first SHOW cycle.
  - SHOW:
    - o_com[digit_sel]=0; o_seg = decoded snapshot digit.
    - The prescaler counts 0..CLK_DIV-1; the dwell is exactly CLK_DIV cycles.
    - At count CLK_DIV-1: go to GUARD if BLANK_CYCLES>0, else advance directly.
  - GUARD:
    - o_com all 1, o_seg=FF, for exactly BLANK_CYCLES cycles.
    - Then advance.
  - Advance:
    - digit_sel = (digit_sel==DIGITS-1) ? 0 : digit_sel+1.
    - Prescaler=0; enter SHOW.
    - On wrap to 0: snapshot<=i_digits/i_dp and pulse o_frame_start.
- Snapshot:
  - Input changes mid-frame never alter the current frame.
  - The snapshot is taken only at frame start, so there is no tearing.
- Leading-zero blanking (i_lz_blank=1, evaluated on the snapshot):
  - Digit k>0 is blanked (o_seg=FF, o_com still driven) if snapshot digits k..DIGITS-1 are all zero and dp[k]=0.
  - Digit 0 is never blanked.
  - A lit dp on digit k stops blanking at k and below.
- i_enable 1->0 in any state: next cycle state=IDLE, o_com all 1, o_seg=FF, digit_sel=0. Re-enable restarts at digit 0.
- Async reset mid-SHOW or GUARD: outputs go to reset values immediately (no clock required).
- DIGITS=1: digit_sel stays 0; every advance is a wrap, so o_frame_start pulses every SHOW entry.
- At most one o_com bit is low in any cycle, including across transitions.
- Widths:
  - The prescaler is wide enough for CLK_DIV-1 and wraps only by explicit clear, never by overflow.
  - The guard counter is sized for BLANK_CYCLES.

Test Plan:
- Reset and enable:
  - Stimulus: CLK_DIV=4, BLANK_CYCLES=2, DIGITS=4, i_digits=16'h1234, i_dp=0; release reset; i_enable=1.
  - Response: o_com sequence 1110 (4 cycles, o_seg=99), 1111 (2 cycles, FF), 1101 (4 cycles, B0), 1111, 1011 (A4), 1111, 0111 (F9), then wrap.
  - o_frame_start high only on each digit-0 SHOW entry.
- Snapshot:
  - Stimulus: change i_digits to 16'h5678 while digit 1 is lit.
  - Response: the remainder of the frame still shows 3,2,1; the next frame shows 8,7,6,5.
- Leading-zero blanking:
  - Stimulus: i_digits=16'h0070, i_lz_blank=1.
  - Response: digit 0 shows C0, digit 1 shows F8, digits 2-3 show FF with commons still scanned.
  - Stimulus: add i_dp=4'b0100.
  - Response: digit 2 shows 40 (0 with dp).
- Disable and reset mid-operation:
  - Stimulus: drop i_enable during GUARD.
  - Response: next cycle o_com=1111, o_seg=FF, o_digit_sel=0; re-enable starts at digit 0.
  - Stimulus: assert i_reset_n=0 asynchronously mid-SHOW.
  - Response: outputs reset before the next clock edge.
- No guard, single digit:
  - Stimulus: BLANK_CYCLES=0.
  - Response: commons switch directly 1110->1101 with no all-off cycle.
  - Stimulus: DIGITS=1.
  - Response: o_com=0 continuously; o_frame_start pulses every CLK_DIV cycles.
- Exclusivity and hex decode:
  - Check: assertion on every cycle that at most one o_com bit is low.
  - Stimulus: i_digits=16'hFEDC.
  - Response: C6, A1, 86, 8E on digits 0..3.

Source files
------------

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Prescaled digit scan, ghosting guard, leading-zero blanking, frame snapshot.
module fnd_scan_controller #(
    parameter int CLK_DIV      = 100000,
    parameter int DIGITS       = 4,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_enable,
    input  logic [4*DIGITS-1:0]   i_digits,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic                  i_lz_blank,
    output logic [DIGITS-1:0]     o_com,
    output logic [7:0]            o_seg,
    output logic [2:0]            o_digit_sel,
    output logic                  o_frame_start
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int GW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam bit HAS_GUARD = (BLANK_CYCLES > 0);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GRD_LAST = HAS_GUARD ? GW'(BLANK_CYCLES - 1) : '0;
    localparam logic [2:0]    SEL_LAST = 3'(DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GUARD} state_t;

    state_t                r_state, w_state;
    logic [2:0]            r_sel, w_sel;
    logic [PW-1:0]         r_pre, w_pre;
    logic [GW-1:0]         r_grd, w_grd;
    logic [4*DIGITS-1:0]   r_snap_d, w_snap_d;
    logic [DIGITS-1:0]     r_snap_dp, w_snap_dp;
    logic [DIGITS-1:0]     r_com, w_com;
    logic [7:0]            r_seg, w_seg;
    logic                  r_fs, w_fs;
    logic                  w_load, w_adv;
    logic [3:0]            w_nib;
    logic                  w_dp_sel, w_blank, w_zero;

    function automatic logic [7:0] seg_dec(input logic [3:0] n);
        case (n)
            4'h0: seg_dec = 8'hC0;
            4'h1: seg_dec = 8'hF9;
            4'h2: seg_dec = 8'hA4;
            4'h3: seg_dec = 8'hB0;
            4'h4: seg_dec = 8'h99;
            4'h5: seg_dec = 8'h92;
            4'h6: seg_dec = 8'h82;
            4'h7: seg_dec = 8'hF8;
            4'h8: seg_dec = 8'h80;
            4'h9: seg_dec = 8'h90;
            4'hA: seg_dec = 8'h88;
            4'hB: seg_dec = 8'h83;
            4'hC: seg_dec = 8'hC6;
            4'hD: seg_dec = 8'hA1;
            4'hE: seg_dec = 8'h86;
            4'hF: seg_dec = 8'h8E;
        endcase
    endfunction

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_pre     <= '0;
            r_grd     <= '0;
            r_snap_d  <= '0;
            r_snap_dp <= '0;
            r_com     <= '1;
            r_seg     <= 8'hFF;
            r_fs      <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_sel     <= w_sel;
            r_pre     <= w_pre;
            r_grd     <= w_grd;
            r_snap_d  <= w_snap_d;
            r_snap_dp <= w_snap_dp;
            r_com     <= w_com;
            r_seg     <= w_seg;
            r_fs      <= w_fs;
        end
    end

    always_comb begin
        w_state = r_state;
        w_sel   = r_sel;
        w_pre   = r_pre;
        w_grd   = r_grd;
        w_load  = 1'b0;
        w_adv   = 1'b0;
        if (!i_enable) begin
            w_state = S_IDLE;
            w_sel   = '0;
            w_pre   = '0;
            w_grd   = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_state = S_SHOW;
                    w_sel   = '0;
                    w_pre   = '0;
                    w_load  = 1'b1;
                end
                S_SHOW: begin
                    if (r_pre == PRE_LAST) begin
                        if (HAS_GUARD) begin
                            w_state = S_GUARD;
                            w_grd   = '0;
                        end else begin
                            w_adv = 1'b1;
                        end
                    end else begin
                        w_pre = r_pre + 1'b1;
                    end
                end
                S_GUARD: begin
                    if (r_grd == GRD_LAST) w_adv = 1'b1;
                    else                   w_grd = r_grd + 1'b1;
                end
                default: w_state = S_IDLE;
            endcase
            if (w_adv) begin
                w_state = S_SHOW;
                w_pre   = '0;
                if (r_sel == SEL_LAST) begin
                    w_sel  = '0;
                    w_load = 1'b1;
                end else begin
                    w_sel = r_sel + 3'd1;
                end
            end
        end
    end

    // Outputs are decoded from next-state values so they land with the state.
    always_comb begin
        w_snap_d  = w_load ? i_digits : r_snap_d;
        w_snap_dp = w_load ? i_dp : r_snap_dp;
        w_com     = '1;
        w_seg     = 8'hFF;
        w_fs      = w_load && (w_state == S_SHOW);
        w_nib     = '0;
        w_dp_sel  = 1'b0;
        w_blank   = 1'b0;
        w_zero    = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_zero = w_zero && (w_snap_d[4*k +: 4] == 4'h0) && !w_snap_dp[k];
            if (w_sel == 3'(k)) begin
                w_nib    = w_snap_d[4*k +: 4];
                w_dp_sel = w_snap_dp[k];
                w_blank  = (k != 0) && i_lz_blank && w_zero;
                if (w_state == S_SHOW) w_com[k] = 1'b0;
            end
        end
        if (w_state == S_SHOW && !w_blank)
            w_seg = seg_dec(w_nib) & {~w_dp_sel, 7'h7F};
    end

    assign o_com         = r_com;
    assign o_seg         = r_seg;
    assign o_digit_sel   = r_sel;
    assign o_frame_start = r_fs;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: three configurations against a
// time-position model of the scan, plus hand-computed literal checks.
module tb_fnd_scan_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] digits = 16'h1234;
    logic [3:0]  dp = 4'b0;
    logic        lz = 1'b0;

    logic [3:0] oA_com, oB_com;
    logic [0:0] oC_com;
    logic [7:0] oA_seg, oB_seg, oC_seg;
    logic [2:0] oA_sel, oB_sel, oC_sel;
    logic       oA_fs, oB_fs, oC_fs;

    int n_cmp = 0;
    int n_bad = 0;
    int tt = 0;

    always #5 clk = ~clk;

    fnd_scan_controller #(.CLK_DIV(4), .DIGITS(4), .BLANK_CYCLES(2)) dA (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_digits(digits),
        .i_dp(dp), .i_lz_blank(lz), .o_com(oA_com), .o_seg(oA_seg),
        .o_digit_sel(oA_sel), .o_frame_start(oA_fs));

    fnd_scan_controller #(.CLK_DIV(4), .DIGITS(4), .BLANK_CYCLES(0)) dB (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_digits(digits),
        .i_dp(dp), .i_lz_blank(lz), .o_com(oB_com), .o_seg(oB_seg),
        .o_digit_sel(oB_sel), .o_frame_start(oB_fs));

    fnd_scan_controller #(.CLK_DIV(4), .DIGITS(1), .BLANK_CYCLES(0)) dC (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_digits(digits[3:0]),
        .i_dp(dp[0:0]), .i_lz_blank(lz), .o_com(oC_com), .o_seg(oC_seg),
        .o_digit_sel(oC_sel), .o_frame_start(oC_fs));

    int CD[3] = '{4, 4, 4};
    int DG[3] = '{4, 4, 1};
    int BC[3] = '{2, 0, 0};

    int          m_t[3];
    logic [15:0] m_d[3];
    logic [3:0]  m_dp[3];
    logic        m_lz;

    function automatic logic [7:0] dec7(input logic [3:0] n);
        logic [7:0] tbl[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                                8'h82, 8'hF8, 8'h80, 8'h90, 8'h88, 8'h83,
                                8'hC6, 8'hA1, 8'h86, 8'h8E};
        return tbl[n];
    endfunction

    // Model: t counts cycles since enable; position in the frame follows.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_t[i]  <= -1;
                m_d[i]  <= '0;
                m_dp[i] <= '0;
            end
            m_lz <= 1'b0;
        end else begin
            m_lz <= lz;
            for (int i = 0; i < 3; i++) begin
                automatic int nt = en ? m_t[i] + 1 : -1;
                automatic int fl = (CD[i] + BC[i]) * DG[i];
                m_t[i] <= nt;
                if (nt >= 0 && nt % fl == 0) begin
                    m_d[i]  <= digits;
                    m_dp[i] <= dp;
                end
            end
        end
    end

    task automatic model_out(input int i, output logic [3:0] com,
                             output logic [7:0] seg, output logic [2:0] sel,
                             output logic fs);
        int slot, fl, ph, d;
        logic blank;
        com = 4'hF; seg = 8'hFF; sel = 3'd0; fs = 1'b0;
        if (m_t[i] >= 0) begin
            slot = CD[i] + BC[i];
            fl   = slot * DG[i];
            ph   = m_t[i] % slot;
            d    = (m_t[i] / slot) % DG[i];
            sel  = 3'(d);
            fs   = (m_t[i] % fl == 0);
            if (ph < CD[i]) begin
                com = ~(4'b1 << d);
                blank = (d > 0) && m_lz && ((m_d[i] >> (4 * d)) == 0)
                        && ((m_dp[i] >> d) == 0);
                if (!blank)
                    seg = dec7(4'(m_d[i] >> (4 * d))) & ~(8'(m_dp[i][d]) << 7);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s t=%0d got %h want %h", nm, tt, got, want);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] c [3];
        logic [7:0] s [3];
        logic [2:0] l [3];
        logic       f [3];
        for (int i = 0; i < 3; i++) model_out(i, c[i], s[i], l[i], f[i]);
        chk("A.com", 8'(oA_com), 8'(c[0]));
        chk("A.seg", oA_seg, s[0]);
        chk("A.sel", 8'(oA_sel), 8'(l[0]));
        chk("A.fs", 8'(oA_fs), 8'(f[0]));
        chk("B.com", 8'(oB_com), 8'(c[1]));
        chk("B.seg", oB_seg, s[1]);
        chk("B.sel", 8'(oB_sel), 8'(l[1]));
        chk("B.fs", 8'(oB_fs), 8'(f[1]));
        chk("C.com", 8'(oC_com), 8'(c[2][0]));
        chk("C.seg", oC_seg, s[2]);
        chk("C.sel", 8'(oC_sel), 8'(l[2]));
        chk("C.fs", 8'(oC_fs), 8'(f[2]));
        chk("A.onehot", 8'($countones(~oA_com) <= 1), 8'd1);
        chk("B.onehot", 8'($countones(~oB_com) <= 1), 8'd1);
    end

    task automatic to(input int n);
        repeat (n - tt) @(negedge clk);
        tt = n;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst.com", 8'(oA_com), 8'h0F);
        chk("rst.seg", oA_seg, 8'hFF);
        chk("rst.fs", 8'(oA_fs), 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        tt = 0;
        chk("L.t0.com", 8'(oA_com), 8'h0E);
        chk("L.t0.seg", oA_seg, 8'h99);
        chk("L.t0.fs", 8'(oA_fs), 8'h01);
        to(1);
        chk("L.t1.fs", 8'(oA_fs), 8'h00);
        to(4);
        chk("L.t4.guard", 8'(oA_com), 8'h0F);
        chk("L.t4.B.com", 8'(oB_com), 8'h0D);
        chk("L.t4.B.seg", oB_seg, 8'hB0);
        chk("L.t4.C.fs", 8'(oC_fs), 8'h01);
        to(6);
        chk("L.t6.com", 8'(oA_com), 8'h0D);
        chk("L.t6.seg", oA_seg, 8'hB0);
        to(12);
        chk("L.t12.seg", oA_seg, 8'hA4);
        to(18);
        chk("L.t18.com", 8'(oA_com), 8'h07);
        chk("L.t18.seg", oA_seg, 8'hF9);
        to(24);
        chk("L.t24.fs", 8'(oA_fs), 8'h01);
        to(31);
        digits = 16'h5678;
        to(36);
        chk("L.snap.t36", oA_seg, 8'hA4);
        to(42);
        chk("L.snap.t42", oA_seg, 8'hF9);
        to(48);
        chk("L.snap.t48", oA_seg, 8'h80);
        to(54);
        chk("L.snap.t54", oA_seg, 8'hF8);
        to(55);
        digits = 16'h0070;
        lz = 1'b1;
        to(72);
        chk("L.lz.d0", oA_seg, 8'hC0);
        to(78);
        chk("L.lz.d1", oA_seg, 8'hF8);
        to(84);
        chk("L.lz.d2.com", 8'(oA_com), 8'h0B);
        chk("L.lz.d2.seg", oA_seg, 8'hFF);
        to(91);
        dp = 4'b0100;
        to(108);
        chk("L.lzdp.d2", oA_seg, 8'h40);
        to(114);
        chk("L.lzdp.d3", oA_seg, 8'hFF);
        to(115);
        digits = 16'hFEDC;
        lz = 1'b0;
        dp = 4'b0;
        to(120);
        chk("L.hex.C", oA_seg, 8'hC6);
        to(126);
        chk("L.hex.d", oA_seg, 8'hA1);
        to(132);
        chk("L.hex.E", oA_seg, 8'h86);
        to(138);
        chk("L.hex.F", oA_seg, 8'h8E);
        to(154);
        en = 1'b0;
        to(155);
        chk("L.dis.com", 8'(oA_com), 8'h0F);
        chk("L.dis.seg", oA_seg, 8'hFF);
        chk("L.dis.sel", 8'(oA_sel), 8'h00);
        to(157);
        en = 1'b1;
        to(158);
        chk("L.reen.com", 8'(oA_com), 8'h0E);
        chk("L.reen.seg", oA_seg, 8'hC6);
        to(160);
        #2 rst_n = 1'b0;
        #1;
        chk("L.arst.com", 8'(oA_com), 8'h0F);
        chk("L.arst.seg", oA_seg, 8'hFF);
        chk("L.arst.C", 8'(oC_com), 8'h01);
        to(163);
        rst_n = 1'b1;
        to(168);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
